friscv_rst_ctrl: RTL and testbench

Parametrised reset sequencer and watchdog that drives the reset inputs of the FRiscV pipelined core, its memories and its peripherals inside the FPGA wrapper.
- Takes the board/bench reset (rst_n) and synchronises its deassertion.
- Releases NUM_DOMAINS reset domains in a staged order.
- Re-applies reset on a software request or a watchdog timeout, and reports the cause.
- Replaces fixed-delay reset generation with configurable hold, staging and restart behaviour.

---
 rtl/friscv_rst_ctrl.sv | 104 ++++++++++
 tb/tb_friscv_rst_ctrl.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/friscv_rst_ctrl.sv
// friscv_rst_ctrl: reset sequencer with staged domain release, software reset and watchdog.
// Domains are released low-index first; a watchdog or software re-reset restarts from HOLD.
module friscv_rst_ctrl #(
   parameter int NUM_DOMAINS = 2,
   parameter int SYNC_STAGES = 2,
   parameter int HOLD_CYCLES = 8,
   parameter int STAGE_GAP   = 4,
   parameter int WDT_WIDTH   = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   sw_rst_req_i,
   input  logic                   wdt_en_i,
   input  logic                   wdt_kick_i,
   input  logic [WDT_WIDTH-1:0]   wdt_limit_i,
   output logic [NUM_DOMAINS-1:0] domain_rst_n_o,
   output logic                   rst_done_o,
   output logic                   wdt_fired_o,
   output logic [1:0]             rst_cause_o
);
   localparam logic [1:0] S_HOLD = 2'd0;
   localparam logic [1:0] S_REL  = 2'd1;
   localparam logic [1:0] S_RUN  = 2'd2;
   localparam int CW = $clog2(HOLD_CYCLES + STAGE_GAP + 1);
   localparam logic [NUM_DOMAINS-1:0] DOM_ONE = NUM_DOMAINS'(1);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [1:0]             state_q, state_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [NUM_DOMAINS-1:0] dom_q, dom_d;
   logic [WDT_WIDTH-1:0]   wdt_q, wdt_d;
   logic                   fired_q, fired_d;
   logic [1:0]             cause_q, cause_d;
   logic                   synced, wdt_on, wdt_fire;

   assign synced   = sync_q[SYNC_STAGES-1];
   assign wdt_on   = (state_q == S_RUN) && (wdt_limit_i != '0);
   assign wdt_fire = wdt_on && !wdt_kick_i && (wdt_q == wdt_limit_i);

   always_comb begin
      sync_d  = {sync_q[SYNC_STAGES-2:0], 1'b1};
      state_d = state_q;
      cnt_d   = cnt_q;
      dom_d   = dom_q;
      wdt_d   = wdt_q;
      fired_d = fired_q;
      cause_d = cause_q;
      if (synced) begin
         if (state_q == S_HOLD) begin
            if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
               state_d = S_REL;
               cnt_d   = '0;
               dom_d   = DOM_ONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end else if (state_q == S_REL) begin
            // Shifting in ones keeps already-released domains released.
            if (&dom_q) begin
               state_d = S_RUN;
            end else if (cnt_q == CW'(STAGE_GAP - 1)) begin
               cnt_d = '0;
               dom_d = (dom_q << 1) | DOM_ONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end else if (wdt_fire || sw_rst_req_i) begin
            state_d = S_HOLD;
            cnt_d   = '0;
            dom_d   = '0;
            wdt_d   = '0;
            fired_d = fired_q | wdt_fire;
            cause_d = wdt_fire ? 2'b10 : 2'b01;
         end else if (wdt_on) begin
            wdt_d = wdt_kick_i ? '0 : (wdt_en_i && !(&wdt_q)) ? wdt_q + 1'b1 : wdt_q;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q  <= '0;
         state_q <= S_HOLD;
         cnt_q   <= '0;
         dom_q   <= '0;
         wdt_q   <= '0;
         fired_q <= 1'b0;
         cause_q <= 2'b00;
      end else begin
         sync_q  <= sync_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dom_q   <= dom_d;
         wdt_q   <= wdt_d;
         fired_q <= fired_d;
         cause_q <= cause_d;
      end
   end

   assign domain_rst_n_o = dom_q;
   assign rst_done_o     = (state_q == S_RUN);
   assign wdt_fired_o    = fired_q;
   assign rst_cause_o    = cause_q;
endmodule

// File: tb/tb_friscv_rst_ctrl.sv
// tb_friscv_rst_ctrl: directed vector table for power-on and software reset, plus
// hand-written watchdog, kick, priority and mid-sequence reset sequences.
module tb_friscv_rst_ctrl;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        sw = 1'b0, en = 1'b0, kick = 1'b0;
   logic [15:0] limit = '0;
   logic [1:0]  dom;
   logic        done, fired;
   logic [1:0]  cause;
   int          checks = 0, errors = 0;

   typedef struct {
      logic       sw;
      logic [1:0] dom;
      logic       done;
      logic [1:0] cause;
      logic       fired;
   } vec_t;
   vec_t vq[$];

   friscv_rst_ctrl dut (
      .clk(clk), .rst_n(rst_n), .sw_rst_req_i(sw), .wdt_en_i(en), .wdt_kick_i(kick),
      .wdt_limit_i(limit), .domain_rst_n_o(dom), .rst_done_o(done),
      .wdt_fired_o(fired), .rst_cause_o(cause)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic void add(input logic s, input logic [1:0] d, input logic dn,
                               input logic [1:0] c, input logic f);
      vec_t v;
      v.sw = s; v.dom = d; v.done = dn; v.cause = c; v.fired = f;
      vq.push_back(v);
   endfunction

   task automatic run_vecs(input int lo, input int hi);
      for (int i = lo; i < hi; i++) begin
         sw = vq[i].sw;
         @(posedge clk); #1;
         sw = 1'b0;
         chk($sformatf("vec%0d", i + 1),
             {27'd0, dom, done, cause, fired},
             {27'd0, vq[i].dom, vq[i].done, vq[i].cause, vq[i].fired});
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   initial begin
      bit ok;
      // power-on: entry i checks state after edge i+1 following rst_n rise
      repeat (9) add(0, 2'b00, 0, 2'b00, 0);
      repeat (4) add(0, 2'b01, 0, 2'b00, 0);
      add(0, 2'b11, 0, 2'b00, 0);
      repeat (2) add(0, 2'b11, 1, 2'b00, 0);
      // software reset pulse sampled at edge 17
      add(1, 2'b00, 0, 2'b01, 0);
      repeat (7) add(0, 2'b00, 0, 2'b01, 0);
      repeat (4) add(0, 2'b01, 0, 2'b01, 0);
      add(0, 2'b11, 0, 2'b01, 0);
      add(0, 2'b11, 1, 2'b01, 0);

      repeat (5) @(posedge clk);
      #1;
      chk("reset_state", {27'd0, dom, done, cause, fired}, 32'd0);
      @(negedge clk) rst_n = 1'b1;
      run_vecs(0, vq.size());

      // watchdog timeout: counter reaches 20 after 20 edges, fires on the 21st
      limit = 16'd20; en = 1'b1;
      tick(20);
      chk("wdt_not_yet", {31'd0, done}, 32'd1);
      tick(1);
      chk("wdt_fire_dom", {30'd0, dom}, 32'd0);
      chk("wdt_fire_cause", {30'd0, cause}, 32'd2);
      chk("wdt_fired", {31'd0, fired}, 32'd1);
      en = 1'b0;
      tick(7);
      chk("wdt_hold7", {30'd0, dom}, 32'd0);
      tick(1);
      chk("wdt_rel0", {30'd0, dom}, 32'd1);
      tick(4);
      chk("wdt_rel1", {30'd0, dom}, 32'd3);
      tick(1);
      chk("wdt_sticky", {29'd0, done, fired, cause == 2'b10}, 32'h7);

      // periodic kick keeps the watchdog quiet
      en = 1'b1; ok = 1'b1;
      for (int i = 0; i < 200; i++) begin
         kick = (i % 15 == 14);
         tick(1);
         if (!done) ok = 1'b0;
      end
      kick = 1'b0;
      chk("kick_no_fire", {31'd0, ok}, 32'd1);
      limit = '0; ok = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         tick(1);
         if (!done) ok = 1'b0;
      end
      chk("disabled_no_fire", {31'd0, ok}, 32'd1);

      // kick exactly when counter == limit
      limit = 16'd20; kick = 1'b1;
      tick(1);
      kick = 1'b0;
      tick(20);
      kick = 1'b1;
      tick(1);
      kick = 1'b0;
      chk("kick_at_limit", {31'd0, done}, 32'd1);
      tick(20);
      chk("count_to_limit", {31'd0, done}, 32'd1);
      // fire and software request on the same edge
      sw = 1'b1;
      tick(1);
      sw = 1'b0; en = 1'b0;
      chk("prio_dom", {30'd0, dom}, 32'd0);
      chk("prio_cause", {30'd0, cause}, 32'd2);

      // assert rst_n between domain 0 and domain 1 release
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         tick(1);
         if (dom == 2'b01) ok = 1'b1;
      end
      chk("reach_dom0", {31'd0, ok}, 32'd1);
      #1 rst_n = 1'b0;
      #1 chk("async_reset", {27'd0, dom, done, cause, fired}, 32'd0);
      repeat (5) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      run_vecs(0, 16);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
